// File: rtl/multi_tick_accum.sv
// Multi-channel accumulator register file with LOAD/ADD/CLEAR commands,
// a multi-cycle CLEAR_ALL sweep, and combinational and registered channel sums.
module multi_tick_accum #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  localparam int CW      = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CW-1:0]       cmd_ch,
  input  logic [WIDTH-1:0]    cmd_data,
  input  logic [CW-1:0]       rd_sel,
  output logic [WIDTH-1:0]    rd_data,
  output logic [WIDTH+CW-1:0] sum_ret,
  output logic [WIDTH+CW-1:0] sum_q,
  output logic                sum_valid,
  output logic                busy,
  output logic [15:0]         op_count
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [1:0] OP_LOAD      = 2'b00;
  localparam logic [1:0] OP_ADD       = 2'b01;
  localparam logic [1:0] OP_CLEAR_ONE = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

  state_t           state, state_nxt;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] regs [CHANNELS];
  logic             accept;
  logic             wr_en;
  logic [CW-1:0]    wr_ch;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH:0]   add_full;

  assign accept   = cmd_valid & cmd_ready;
  assign add_full = {1'b0, regs[cmd_ch]} + {1'b0, cmd_data};

  // Next state, handshake and the single register write port; a sweep step
  // takes priority because commands are not accepted in SWEEP.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    wr_en     = 1'b0;
    wr_ch     = cmd_ch;
    wr_val    = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              wr_en  = 1'b1;
              wr_val = cmd_data;
            end
            OP_ADD: begin
              wr_en  = 1'b1;
              wr_val = (SATURATE != 0 && add_full[WIDTH]) ? '1 : add_full[WIDTH-1:0];
            end
            OP_CLEAR_ONE: wr_en = 1'b1;
            OP_CLEAR_ALL: state_nxt = SWEEP;
            default: ;
          endcase
        end
      end
      SWEEP: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        wr_ch = idx;
        if (idx == CW'(CHANNELS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      op_count  <= '0;
      sum_q     <= '0;
      sum_valid <= 1'b1;
      for (int unsigned i = 0; i < CHANNELS; i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= (state == SWEEP) ? idx + 1'b1 : '0;
      sum_q     <= sum_ret;
      sum_valid <= ~wr_en;
      if (accept) op_count <= op_count + 16'd1;
      if (wr_en) regs[wr_ch] <= wr_val;
    end
  end

  always_comb begin
    sum_ret = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      sum_ret = sum_ret + {{CW{1'b0}}, regs[i]};
  end

  assign rd_data = regs[rd_sel];

endmodule

// File: tb/tb_multi_tick_accum.sv
// Checks a wrapping and a saturating multi_tick_accum side by side against a
// behavioural model, plus hand-computed scenario expectations.
module tb_multi_tick_accum;

  localparam int W = 8;
  localparam int N = 4;

  logic       clock;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [1:0] cmd_ch;
  logic [7:0] cmd_data;
  logic [1:0] rd_sel;

  logic       ready0, ready1, busy0, busy1, sv0, sv1;
  logic [7:0] rd0, rd1;
  logic [9:0] sr0, sr1, sq0, sq1;
  logic [15:0] oc0, oc1;

  int checks = 0;
  int errors = 0;

  multi_tick_accum #(.WIDTH(W), .CHANNELS(N), .SATURATE(0)) dut_wrap (
    .clock(clock), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready0),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .rd_sel(rd_sel),
    .rd_data(rd0), .sum_ret(sr0), .sum_q(sq0), .sum_valid(sv0), .busy(busy0),
    .op_count(oc0));

  multi_tick_accum #(.WIDTH(W), .CHANNELS(N), .SATURATE(1)) dut_sat (
    .clock(clock), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready1),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .rd_sel(rd_sel),
    .rd_data(rd1), .sum_ret(sr1), .sum_q(sq1), .sum_valid(sv1), .busy(busy1),
    .op_count(oc1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 wraps, index 1 saturates.
  int m_reg [2][N];
  int m_sumq [2];
  bit m_sumv;
  int m_op;
  int sw_left;
  int sw_pos;

  function automatic int msum(input int d);
    int s = 0;
    for (int i = 0; i < N; i++) s += m_reg[d][i];
    return s;
  endfunction

  always @(posedge clock or negedge rst_n) begin : model
    int pre [2];
    bit wrote;
    int a;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) m_reg[d][i] = 0;
        m_sumq[d] = 0;
      end
      m_sumv = 1; m_op = 0; sw_left = 0; sw_pos = 0;
    end else begin
      pre[0] = msum(0);
      pre[1] = msum(1);
      wrote = 0;
      if (sw_left > 0) begin
        m_reg[0][sw_pos] = 0;
        m_reg[1][sw_pos] = 0;
        sw_pos++;
        sw_left--;
        wrote = 1;
      end else if (cmd_valid) begin
        m_op = (m_op + 1) % 65536;
        for (int d = 0; d < 2; d++) begin
          case (cmd_op)
            2'd0: m_reg[d][cmd_ch] = cmd_data;
            2'd1: begin
              a = m_reg[d][cmd_ch] + int'(cmd_data);
              m_reg[d][cmd_ch] = (d == 1 && a > 255) ? 255 : a % 256;
            end
            2'd2: m_reg[d][cmd_ch] = 0;
            default: begin sw_left = N; sw_pos = 0; end
          endcase
        end
        wrote = (cmd_op != 2'd3);
      end
      m_sumq[0] = pre[0];
      m_sumq[1] = pre[1];
      m_sumv = !wrote;
    end
  end

  always @(posedge clock) begin : compare
    #1;
    chk("ready0", 32'(ready0), 32'(sw_left == 0));
    chk("ready1", 32'(ready1), 32'(sw_left == 0));
    chk("busy0", 32'(busy0), 32'(sw_left > 0));
    chk("busy1", 32'(busy1), 32'(sw_left > 0));
    chk("opcnt0", 32'(oc0), m_op);
    chk("opcnt1", 32'(oc1), m_op);
    chk("sumq0", 32'(sq0), m_sumq[0]);
    chk("sumq1", 32'(sq1), m_sumq[1]);
    chk("sumv0", 32'(sv0), 32'(m_sumv));
    chk("sumv1", 32'(sv1), 32'(m_sumv));
    chk("sumret0", 32'(sr0), msum(0));
    chk("sumret1", 32'(sr1), msum(1));
    chk("rd0", 32'(rd0), m_reg[0][rd_sel]);
    chk("rd1", 32'(rd1), m_reg[1][rd_sel]);
  end

  task automatic issue(input logic v, input logic [1:0] op, input logic [1:0] ch,
                       input logic [7:0] data);
    @(negedge clock);
    cmd_valid = v; cmd_op = op; cmd_ch = ch; cmd_data = data;
  endtask

  initial begin : main
    int low_cnt;
    int op_before;
    int r;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_ch = 2'd0; cmd_data = 8'd0; rd_sel = 2'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_opcnt", 32'(oc0), 32'd0);
    chk("rst_sumq", 32'(sq0), 32'd0);
    chk("rst_sumv", 32'(sv0), 32'd1);
    @(negedge clock);
    rst_n = 1'b1;

    // Loads 10,20,30,40
    issue(1, 2'd0, 2'd0, 8'd10);
    issue(1, 2'd0, 2'd1, 8'd20);
    issue(1, 2'd0, 2'd2, 8'd30);
    issue(1, 2'd0, 2'd3, 8'd40);
    @(posedge clock); #1;
    chk("load_sumret", 32'(sr0), 32'd100);
    chk("load_sumv_low", 32'(sv0), 32'd0);
    chk("load_opcnt", 32'(oc0), 32'd4);
    issue(0, 2'd0, 2'd0, 8'd0);
    @(posedge clock); #1;
    chk("load_sumq", 32'(sq0), 32'd100);
    chk("load_sumv_high", 32'(sv0), 32'd1);

    // ADD wrap vs saturate
    issue(1, 2'd0, 2'd2, 8'hF0);
    issue(1, 2'd1, 2'd2, 8'h20);
    issue(0, 2'd0, 2'd0, 8'd0);
    rd_sel = 2'd2;
    #1;
    chk("add_wrap", 32'(rd0), 32'h10);
    chk("add_sat", 32'(rd1), 32'hFF);

    // All channels full, then CLEAR_ALL with a LOAD held during the sweep
    for (int i = 0; i < N; i++) issue(1, 2'd0, 2'(i), 8'hFF);
    issue(0, 2'd0, 2'd0, 8'd0);
    #1;
    chk("max_sum0", 32'(sr0), 32'h3FC);
    chk("max_sum1", 32'(sr1), 32'h3FC);
    op_before = int'(oc0);
    issue(1, 2'd3, 2'(($urandom) % 4), 8'($urandom));
    rd_sel = 2'd1;
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (ready0) cmd_valid = 1'b0;
      else begin
        low_cnt++;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_ch = 2'd1; cmd_data = 8'h55;
      end
    end
    chk("sweep_len", 32'(low_cnt), 32'd4);
    chk("sweep_sum", 32'(sr0), 32'd0);
    chk("sweep_rd_ch1", 32'(rd0), 32'd0);
    chk("sweep_opcnt", 32'(oc0), 32'(op_before + 1));

    // Reset in the second sweep cycle
    issue(1, 2'd0, 2'd3, 8'h77);
    issue(1, 2'd3, 2'd0, 8'd0);
    @(posedge clock);
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_ready", 32'(ready0), 32'd1);
    chk("midrst_opcnt", 32'(oc0), 32'd0);
    chk("midrst_sum", 32'(sr0), 32'd0);
    rd_sel = 2'd3;
    #1;
    chk("midrst_rd3", 32'(rd0), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 9));
      issue($urandom_range(0, 3) != 0,
            (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
            2'($urandom), 8'($urandom));
      rd_sel = 2'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    issue(0, 2'd0, 2'd0, 8'd0);
    repeat (6) @(posedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_tick_accum.md
MULTI_TICK_ACCUM -- requirements
Module: multi_tick_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8: channel register width in bits, minimum 2.
REQ-002 SHALL have parameter CHANNELS, default 4: number of channel registers, a power of two, minimum 2; CW = log2(CHANNELS).
REQ-003 SHALL have parameter SATURATE, default 0: ADD wraps when 0 and clamps at 2^WIDTH-1 when 1.
REQ-004 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered this cycle.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_op  input  2  op: 00 LOAD, 01 ADD, 10 CLEAR_ONE, 11 CLEAR_ALL.
REQ-009 SHALL have port cmd_ch  input  CW  target channel index.
REQ-010 SHALL have port cmd_data  input  WIDTH  operand for LOAD and ADD.
REQ-011 SHALL have port rd_sel  input  CW  read-port channel select.
REQ-012 SHALL have port rd_data  output  WIDTH  combinational value of channel rd_sel.
REQ-013 SHALL have port sum_ret  output  WIDTH+CW  combinational sum of all channel registers.
REQ-014 SHALL have port sum_q  output  WIDTH+CW  registered copy of sum_ret.
REQ-015 SHALL have port sum_valid  output  1  high when sum_q equals the current sum_ret.
REQ-016 SHALL have port busy  output  1  high while in SWEEP.
REQ-017 SHALL have port op_count  output  16  count of accepted commands, wrapping.

Function
REQ-018 SHALL implement an FSM with states IDLE and SWEEP; cmd_ready = 1 in IDLE and 0 in SWEEP; busy = (state == SWEEP).
REQ-019 SHALL, on an accepted LOAD, set reg[cmd_ch] <= cmd_data at that edge.
REQ-020 SHALL, on an accepted ADD, set reg[cmd_ch] <= reg[cmd_ch] + cmd_data, truncated modulo 2^WIDTH when SATURATE=0 and clamped to 2^WIDTH-1 on carry-out when SATURATE=1.
REQ-021 SHALL, on an accepted CLEAR_ONE, set reg[cmd_ch] <= 0; cmd_data is ignored.
REQ-022 SHALL, on an accepted CLEAR_ALL, enter SWEEP with sweep index 0; cmd_ch and cmd_data are ignored.
REQ-023 SHALL, in each SWEEP cycle, clear reg[idx] and increment idx; after clearing idx = CHANNELS-1 it SHALL return to IDLE, so cmd_ready is low for exactly CHANNELS cycles.
REQ-024 SHALL ignore cmd_valid while in SWEEP: no register write and no op_count increment.
REQ-025 SHALL compute sum_ret as the exact, non-overflowing sum of all CHANNELS registers, zero-extended to WIDTH+CW bits.
REQ-026 SHALL update sum_q <= sum_ret on every edge; latency from a register write to sum_q is one cycle after the write edge.
REQ-027 SHALL register sum_valid low for the cycle following any edge that writes a channel register (command or sweep step), and high otherwise.
REQ-028 SHALL increment op_count by 1 on each accepted command, wrapping 0xFFFF -> 0x0000.
REQ-029 SHALL make rd_data and sum_ret reflect register values after the most recent edge, with no bypass of the same-cycle command.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously force all channel registers = 0, sum_q = 0, sum_valid = 1, state = IDLE, sweep idx = 0, op_count = 0; cmd_ready therefore = 1 and busy = 0.
REQ-031 SHALL abort an in-progress SWEEP on reset and resume in IDLE with all outputs at their reset values.

Verification
REQ-032 SHALL be checked with reset-then-loads (WIDTH=8, CHANNELS=4): LOAD ch0..3 = 10, 20, 30, 40 -> sum_ret = 100; sum_q = 100 one cycle after the last load; sum_valid = 0 for that cycle then 1; op_count = 4.
REQ-033 SHALL be checked with ADD wrap (SATURATE=0): LOAD ch2 = 0xF0, then ADD ch2 0x20 -> rd_data (rd_sel = 2) = 0x10.
REQ-034 SHALL be checked with ADD saturate (SATURATE=1): same stimulus as REQ-033 -> rd_data = 0xFF.
REQ-035 SHALL be checked with CLEAR_ALL: all channels = 0xFF, accept CLEAR_ALL -> cmd_ready = 0 for 4 cycles; a cmd_valid LOAD held during SWEEP is not applied; sum_ret = 0 after the 4th sweep edge; op_count increments once.
REQ-036 SHALL be checked with reset mid-sweep: assert rst_n = 0 in the 2nd SWEEP cycle -> busy = 0, cmd_ready = 1, all regs and op_count = 0 immediately, without waiting for a clock edge.
REQ-037 SHALL be checked with maximum sum: all channels = 0xFF -> sum_ret = 0x3FC with no overflow into a 10-bit result.
